// File: rtl/tile_draw_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tile_draw_scheduler - draws 4x4 stage tiles through the shared VGA pixel port
// Rev 1.0
// ----------------------------------------------------------------------------
module tile_draw_scheduler #(
  parameter int MAP_W    = 11,
  parameter int MAP_H    = 11,
  parameter int X_ORIGIN = 58,
  parameter int Y_ORIGIN = 38
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       redraw_req,
  input  logic [1:0] upd_req,
  input  logic [3:0] upd_tx0,
  input  logic [3:0] upd_ty0,
  input  logic [3:0] upd_tx1,
  input  logic [3:0] upd_ty1,
  output logic [1:0] upd_ack,
  output logic [6:0] map_addr,
  input  logic [3:0] map_data,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAW  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_TX = 4'(MAP_W - 1);
  localparam logic [3:0] LAST_TY = 4'(MAP_H - 1);

  state_t     state_q, state_d;
  logic       pend_q, pend_d;
  logic       rr_q, rr_d;
  logic       redraw_q, redraw_d;
  logic [3:0] tx_q, tx_d;
  logic [3:0] ty_q, ty_d;
  logic [3:0] code_q, code_d;
  logic [3:0] pix_q, pix_d;
  logic [6:0] addr_q, addr_d;

  logic       sel;
  logic [3:0] sel_tx, sel_ty;
  logic       sel_ok;
  logic       last_col, last_tile;
  logic [3:0] next_tx, next_ty;

  function automatic logic [6:0] tile_addr(input logic [3:0] tx, input logic [3:0] ty);
    return 7'(ty) * 7'(MAP_W) + 7'(tx);
  endfunction

  // With both players requesting the pointer decides; otherwise the lone requester wins.
  always_comb begin
    sel    = (upd_req == 2'b11) ? rr_q : upd_req[1];
    sel_tx = sel ? upd_tx1 : upd_tx0;
    sel_ty = sel ? upd_ty1 : upd_ty0;
    sel_ok = (sel_tx <= LAST_TX) && (sel_ty <= LAST_TY);
  end

  assign last_col  = (tx_q == LAST_TX);
  assign last_tile = last_col && (ty_q == LAST_TY);
  assign next_tx   = last_col ? 4'd0 : tx_q + 4'd1;
  assign next_ty   = last_col ? ty_q + 4'd1 : ty_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      rr_q     <= 1'b0;
      redraw_q <= 1'b0;
      tx_q     <= 4'd0;
      ty_q     <= 4'd0;
      code_q   <= 4'd0;
      pix_q    <= 4'd0;
      addr_q   <= 7'd0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      rr_q     <= rr_d;
      redraw_q <= redraw_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      code_q   <= code_d;
      pix_q    <= pix_d;
      addr_q   <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    rr_d       = rr_q;
    redraw_d   = redraw_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    code_d     = code_q;
    pix_d      = pix_q;
    addr_d     = addr_q;
    upd_ack    = 2'b00;
    frame_done = 1'b0;

    // A pulse during an active redraw is absorbed; otherwise it is remembered.
    if (redraw_req && !((state_q != S_IDLE) && redraw_q)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d   = 1'b0;
          redraw_d = 1'b1;
          tx_d     = 4'd0;
          ty_d     = 4'd0;
          addr_d   = 7'd0;
          state_d  = S_FETCH;
        end else if (upd_req != 2'b00) begin
          upd_ack = sel ? 2'b10 : 2'b01;
          rr_d    = ~sel;
          if (sel_ok) begin
            redraw_d = 1'b0;
            tx_d     = sel_tx;
            ty_d     = sel_ty;
            addr_d   = tile_addr(sel_tx, sel_ty);
            state_d  = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        code_d  = map_data;
        pix_d   = 4'd0;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        pix_d = pix_q + 4'd1;
        if (pix_q == 4'd15) begin
          if (redraw_q && !last_tile) begin
            tx_d    = next_tx;
            ty_d    = next_ty;
            addr_d  = tile_addr(next_tx, next_ty);
            state_d = S_FETCH;
          end else begin
            frame_done = redraw_q;
            state_d    = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    plot       = (state_q == S_DRAW);
    x_out      = 8'd0;
    y_out      = 7'd0;
    colour_out = 3'b000;
    if (plot) begin
      x_out = 8'(X_ORIGIN) + {2'b00, tx_q, 2'b00} + {6'd0, pix_q[1:0]};
      y_out = 7'(Y_ORIGIN) + {1'b0, ty_q, 2'b00} + {5'd0, pix_q[3:2]};
      case (code_q)
        4'd0:    colour_out = 3'b010;
        4'd1:    colour_out = 3'b111;
        4'd2:    colour_out = 3'b100;
        4'd3:    colour_out = 3'b001;
        4'd4:    colour_out = 3'b110;
        4'd5:    colour_out = 3'b011;
        4'd6:    colour_out = 3'b101;
        default: colour_out = 3'b000;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign map_addr = addr_q;

endmodule
`default_nettype wire
